// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the multiply/divide unit.
//   - MDU_* operation codes. The decode controller and the MDU both use these
//     names, so no raw op-code literals appear in either block.
//   - FSM state type and the pending-result record held while an op is busy.
//   - isLongOp(): true for the multi-cycle ops (mult/multu/div/divu).
package mdu_pkg;

    localparam logic [3:0] MDU_NONE  = 4'd0;
    localparam logic [3:0] MDU_MULT  = 4'd1;
    localparam logic [3:0] MDU_MULTU = 4'd2;
    localparam logic [3:0] MDU_DIV   = 4'd3;
    localparam logic [3:0] MDU_DIVU  = 4'd4;
    localparam logic [3:0] MDU_MFHI  = 4'd5;
    localparam logic [3:0] MDU_MFLO  = 4'd6;
    localparam logic [3:0] MDU_MTHI  = 4'd7;
    localparam logic [3:0] MDU_MTLO  = 4'd8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mduState_e;

    // Result captured at start and held until the commit edge.
    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        divByZero;
    } pendRes_t;

    function automatic logic isLongOp(input logic [3:0] op);
        return (op == MDU_MULT) || (op == MDU_MULTU) ||
               (op == MDU_DIV)  || (op == MDU_DIVU);
    endfunction

    function automatic logic isMultOp(input logic [3:0] op);
        return (op == MDU_MULT) || (op == MDU_MULTU);
    endfunction

endpackage

// File: rtl/mdu_arith.sv
// mdu_arith: combinational multiply/divide datapath.
//   a, b       : 32-bit operands (rs, rt)
//   op         : MDU_* operation code
//   result     : {hi, lo}. Multiply: 64-bit product. Divide: {remainder, quotient}.
//                Zero for any other op.
//   divByZero  : set for DIV/DIVU with b == 0; result is then meaningless.
//
// One multiplier and one divider are shared between the signed and unsigned
// flavours. Signed multiply sign-extends both operands to 64 bits, so the low
// 64 bits of the product are the exact signed result. Signed divide works on
// magnitudes and re-applies signs afterwards: quotient is negative when the
// operand signs differ (truncation toward zero), remainder follows the
// dividend. 0x80000000 / -1 falls out naturally: both magnitudes are
// 0x80000000 and 1, quotient 0x80000000 keeps its (unsigned) value, remainder 0.
module mdu_arith
    import mdu_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [3:0]  op,
    output logic [63:0] result,
    output logic        divByZero
);

    logic        mulSigned;
    logic        divSigned;
    logic [63:0] mulA;
    logic [63:0] mulB;
    logic [63:0] product;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic [31:0] quotMag;
    logic [31:0] remMag;
    logic [31:0] quot;
    logic [31:0] rem;

    assign mulSigned = (op == MDU_MULT);
    assign divSigned = (op == MDU_DIV);

    assign mulA    = {{32{mulSigned & a[31]}}, a};
    assign mulB    = {{32{mulSigned & b[31]}}, b};
    assign product = mulA * mulB;

    // Magnitudes for signed divide; a zero divisor is replaced by 1 so the
    // divider never sees /0 (the result is discarded anyway).
    assign dividend = (divSigned && a[31]) ? (32'd0 - a) : a;
    assign divisor  = (b == 32'd0) ? 32'd1 :
                      ((divSigned && b[31]) ? (32'd0 - b) : b);
    assign quotMag  = dividend / divisor;
    assign remMag   = dividend % divisor;

    assign quot = (divSigned && (a[31] ^ b[31])) ? (32'd0 - quotMag) : quotMag;
    assign rem  = (divSigned && a[31]) ? (32'd0 - remMag) : remMag;

    always_comb begin
        result    = 64'd0;
        divByZero = 1'b0;
        if (isMultOp(op)) begin
            result = product;
        end else if ((op == MDU_DIV) || (op == MDU_DIVU)) begin
            result    = {rem, quot};
            divByZero = (b == 32'd0);
        end
    end

endmodule

// File: rtl/mdu.sv
// mdu: E-stage multiply/divide unit owning the architectural HI/LO registers.
//   clk       : single clock, rising edge
//   reset     : synchronous, active-high
//   start     : E-stage op valid (mult/multu/div/divu/mthi/mtlo)
//   mdu_type  : MDU_* operation code (0 = none)
//   a, b      : forwarded rs / rt values
//   busy      : multi-cycle op in flight
//   rd_data   : HI for MFHI, LO for MFLO, else 0 (combinational)
//   hi, lo    : architectural HI / LO
//
// Handshake: start is a one-cycle strobe accepted only while busy is low.
// A long op accepted on edge E raises busy for exactly MULT_CYCLES or
// DIV_CYCLES cycles after E; HI/LO update on the edge that drops busy, so the
// first cycle with busy low already shows the new values and may accept the
// next start. start while busy is high is ignored; hazard logic is expected to
// hold MDU instructions in D until busy falls.
module mdu
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  mdu_type,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] rd_data,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    mduState_e   state;
    mduState_e   stateNext;
    logic [CNT_W-1:0] counter;
    logic [CNT_W-1:0] counterNext;
    pendRes_t    pend;
    pendRes_t    pendNext;
    logic [31:0] hiReg;
    logic [31:0] hiNext;
    logic [31:0] loReg;
    logic [31:0] loNext;

    logic [63:0] arithResult;
    logic        arithDivByZero;

    mdu_arith uArith (
        .a         (a),
        .b         (b),
        .op        (mdu_type),
        .result    (arithResult),
        .divByZero (arithDivByZero)
    );

    always_comb begin
        stateNext   = state;
        counterNext = counter;
        pendNext    = pend;
        hiNext      = hiReg;
        loNext      = loReg;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    if (isLongOp(mdu_type)) begin
                        pendNext.hi        = arithResult[63:32];
                        pendNext.lo        = arithResult[31:0];
                        pendNext.divByZero = arithDivByZero;
                        counterNext        = isMultOp(mdu_type) ? CNT_W'(MULT_CYCLES)
                                                                : CNT_W'(DIV_CYCLES);
                        stateNext          = ST_BUSY;
                    end else if (mdu_type == MDU_MTHI) begin
                        hiNext = a;
                    end else if (mdu_type == MDU_MTLO) begin
                        loNext = a;
                    end
                end
            end

            ST_BUSY: begin
                counterNext = counter - CNT_W'(1);
                // Last busy cycle: commit on the edge that takes counter 1 -> 0.
                if (counter == CNT_W'(1)) begin
                    stateNext = ST_IDLE;
                    if (!pend.divByZero) begin
                        hiNext = pend.hi;
                        loNext = pend.lo;
                    end
                end
            end

            default: begin
                stateNext = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            counter <= '0;
            pend    <= '0;
            hiReg   <= 32'd0;
            loReg   <= 32'd0;
        end else begin
            state   <= stateNext;
            counter <= counterNext;
            pend    <= pendNext;
            hiReg   <= hiNext;
            loReg   <= loNext;
        end
    end

    assign busy = (state == ST_BUSY);
    assign hi   = hiReg;
    assign lo   = loReg;

    // Reads see the committed registers, i.e. the old values while busy.
    always_comb begin
        rd_data = 32'd0;
        if (mdu_type == MDU_MFHI) begin
            rd_data = hiReg;
        end else if (mdu_type == MDU_MFLO) begin
            rd_data = loReg;
        end
    end

endmodule

// File: tb/tb_mdu.sv
// tb_mdu: self-checking bench for mdu. A behavioural model (plain 64-bit
// integer arithmetic on the current {hi, lo}) predicts every result; expected
// commits go through a queue and are popped on the cycle busy must fall.
module tb_mdu;
    import mdu_pkg::*;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        clk;
    logic        reset;
    logic        start;
    logic [3:0]  mdu_type;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic [31:0] rd_data;
    logic [31:0] hi;
    logic [31:0] lo;

    int asserts  = 0;
    int failures = 0;

    logic [63:0] model;      // architectural {hi, lo} as the bench believes it
    logic [63:0] expQ[$];

    mdu #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .mdu_type (mdu_type),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .rd_data  (rd_data),
        .hi       (hi),
        .lo       (lo)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic logic [63:0] refResult(input logic [3:0] op, input logic [31:0] x,
                                              input logic [31:0] y, input logic [63:0] cur);
        longint sx;
        longint sy;
        longint q;
        longint r;
        logic [63:0] res;
        sx  = longint'(int'(x));
        sy  = longint'(int'(y));
        res = cur;
        case (op)
            MDU_MULT:  res = 64'(sx * sy);
            MDU_MULTU: res = {32'd0, x} * {32'd0, y};
            MDU_DIV: begin
                if (y != 32'd0) begin
                    q   = sx / sy;
                    r   = sx % sy;
                    res = {r[31:0], q[31:0]};
                end
            end
            MDU_DIVU:  if (y != 32'd0) res = {x % y, x / y};
            MDU_MTHI:  res = {x, cur[31:0]};
            MDU_MTLO:  res = {cur[63:32], x};
            default:   res = cur;
        endcase
        return res;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // One-cycle MTHI/MTLO write; checks the value lands next cycle with busy low.
    task automatic writeReg(input logic [3:0] op, input logic [31:0] val);
        logic [63:0] expV;
        expV     = refResult(op, val, 32'd0, model);
        start    = 1'b1;
        mdu_type = op;
        a        = val;
        nextCycle();
        start    = 1'b0;
        mdu_type = MDU_NONE;
        asserts++;
        if ({hi, lo} !== expV || busy !== 1'b0) begin
            failures++;
            $display("FAIL move_to op=%0d: hi=%h lo=%h busy=%b expected hi=%h lo=%h busy=0",
                     op, hi, lo, busy, expV[63:32], expV[31:0]);
        end
        model = expV;
    endtask

    // Long op: checks busy for every one of the N cycles, old HI/LO readable
    // throughout, and the committed result the cycle busy falls.
    // intrudeAt > 0 fires a second start (intrudeOp) in that busy cycle.
    task automatic runLongOp(input string name, input logic [3:0] op, input logic [31:0] x,
                             input logic [31:0] y, input int intrudeAt, input logic [3:0] intrudeOp);
        logic [63:0] oldV;
        logic [63:0] expV;
        int          n;
        oldV = model;
        expQ.push_back(refResult(op, x, y, model));
        n        = ((op == MDU_MULT) || (op == MDU_MULTU)) ? MULT_N : DIV_N;
        start    = 1'b1;
        mdu_type = op;
        a        = x;
        b        = y;
        nextCycle();
        for (int k = 1; k <= n; k++) begin
            if (k > 1) nextCycle();
            start    = 1'b0;
            mdu_type = (k % 2 == 1) ? MDU_MFHI : MDU_MFLO;
            a        = $urandom;
            b        = $urandom;
            #1;
            asserts++;
            if (busy !== 1'b1) begin
                failures++;
                $display("FAIL %s busy cycle %0d: busy=%b expected 1", name, k, busy);
            end
            asserts++;
            if (rd_data !== ((k % 2 == 1) ? oldV[63:32] : oldV[31:0])) begin
                failures++;
                $display("FAIL %s old read cycle %0d: rd_data=%h expected %h", name, k, rd_data,
                         (k % 2 == 1) ? oldV[63:32] : oldV[31:0]);
            end
            if (k == intrudeAt) begin
                start    = 1'b1;
                mdu_type = intrudeOp;
            end
        end
        nextCycle();
        start    = 1'b0;
        mdu_type = MDU_MFHI;
        #1;
        expV = expQ.pop_front();
        asserts++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL %s busy end: busy=%b expected 0 after %0d cycles", name, busy, n);
        end
        asserts++;
        if ({hi, lo} !== expV) begin
            failures++;
            $display("FAIL %s result: hi=%h lo=%h expected hi=%h lo=%h", name, hi, lo,
                     expV[63:32], expV[31:0]);
        end
        asserts++;
        if (rd_data !== expV[63:32]) begin
            failures++;
            $display("FAIL %s mfhi after commit: rd_data=%h expected %h", name, rd_data, expV[63:32]);
        end
        model = expV;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset    = 1'b1;
        start    = 1'b0;
        mdu_type = MDU_NONE;
        a        = 32'd0;
        b        = 32'd0;
        nextCycle();
        nextCycle();
        reset = 1'b0;
        model = 64'd0;
        mdu_type = MDU_MFHI;
        #1;
        asserts++;
        if (rd_data !== 32'd0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset mfhi: rd_data=%h busy=%b expected 0/0", rd_data, busy);
        end
        mdu_type = MDU_MFLO;
        #1;
        asserts++;
        if (rd_data !== 32'd0 || hi !== 32'd0 || lo !== 32'd0) begin
            failures++;
            $display("FAIL reset mflo: rd_data=%h hi=%h lo=%h expected 0", rd_data, hi, lo);
        end
        mdu_type = MDU_NONE;
    endtask

    task automatic test_mult();
        writeReg(MDU_MTHI, 32'h1234_5678);
        writeReg(MDU_MTLO, 32'h9ABC_DEF0);
        runLongOp("mult_neg2x3", MDU_MULT, 32'hFFFF_FFFE, 32'd3, 0, MDU_NONE);
        asserts++;
        if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFFA) begin
            failures++;
            $display("FAIL mult literal: hi=%h lo=%h expected FFFFFFFF FFFFFFFA", hi, lo);
        end
        runLongOp("multu_max_x2", MDU_MULTU, 32'hFFFF_FFFF, 32'd2, 0, MDU_NONE);
        asserts++;
        if ({hi, lo} !== 64'h0000_0001_FFFF_FFFE) begin
            failures++;
            $display("FAIL multu literal: hi=%h lo=%h expected 00000001 FFFFFFFE", hi, lo);
        end
    endtask

    task automatic test_div();
        runLongOp("div_neg7_2", MDU_DIV, 32'hFFFF_FFF9, 32'd2, 0, MDU_NONE);
        asserts++;
        if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFFD) begin
            failures++;
            $display("FAIL div literal: hi=%h lo=%h expected FFFFFFFF FFFFFFFD", hi, lo);
        end
        runLongOp("div_overflow", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, MDU_NONE);
        asserts++;
        if ({hi, lo} !== 64'h0000_0000_8000_0000) begin
            failures++;
            $display("FAIL div overflow literal: hi=%h lo=%h expected 00000000 80000000", hi, lo);
        end
        runLongOp("divu_big", MDU_DIVU, 32'hFFFF_FFF9, 32'd2, 0, MDU_NONE);
    endtask

    task automatic test_div_by_zero();
        writeReg(MDU_MTHI, 32'h11);
        writeReg(MDU_MTLO, 32'h22);
        runLongOp("divu_by_zero", MDU_DIVU, 32'd7, 32'd0, 0, MDU_NONE);
        asserts++;
        if (hi !== 32'h11 || lo !== 32'h22) begin
            failures++;
            $display("FAIL divu zero literal: hi=%h lo=%h expected 00000011 00000022", hi, lo);
        end
        runLongOp("div_by_zero", MDU_DIV, 32'h8000_0001, 32'd0, 0, MDU_NONE);
    endtask

    task automatic test_move_to();
        writeReg(MDU_MTHI, 32'hDEAD_BEEF);
        writeReg(MDU_MTLO, 32'hCAFE_F00D);
    endtask

    task automatic test_start_while_busy();
        runLongOp("div_ignore_mult", MDU_DIV, 32'd1000, 32'hFFFF_FFFD, 2, MDU_MULTU);
        runLongOp("mult_ignore_mthi", MDU_MULT, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 3, MDU_MTHI);
    endtask

    task automatic test_back_to_back();
        runLongOp("b2b_multu", MDU_MULTU, 32'h0001_0000, 32'h0001_0000, 0, MDU_NONE);
        runLongOp("b2b_div", MDU_DIV, 32'd7, 32'hFFFF_FFFE, 0, MDU_NONE);
        runLongOp("b2b_mult", MDU_MULT, 32'h8000_0000, 32'h8000_0000, 0, MDU_NONE);
    endtask

    task automatic test_reset_mid_op();
        writeReg(MDU_MTHI, 32'hAAAA_5555);
        start    = 1'b1;
        mdu_type = MDU_DIV;
        a        = 32'd100;
        b        = 32'd7;
        nextCycle();
        start = 1'b0;
        mdu_type = MDU_NONE;
        nextCycle();
        nextCycle();
        // Busy cycle 3: reset sampled on the next edge.
        reset = 1'b1;
        nextCycle();
        reset = 1'b0;
        model = 64'd0;
        asserts++;
        if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            failures++;
            $display("FAIL reset_mid: busy=%b hi=%h lo=%h expected 0/0/0", busy, hi, lo);
        end
        for (int k = 0; k < DIV_N + 2; k++) begin
            nextCycle();
            asserts++;
            if (busy !== 1'b0 || {hi, lo} !== 64'd0) begin
                failures++;
                $display("FAIL reset_mid late commit cycle %0d: busy=%b hi=%h lo=%h expected 0",
                         k, busy, hi, lo);
            end
        end
    endtask

    task automatic test_random();
        logic [3:0]  op;
        logic [31:0] x;
        logic [31:0] y;
        logic [63:0] expV;
        for (int i = 0; i < 30; i++) begin
            op = 4'($urandom_range(0, 15));
            x  = $urandom;
            y  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) y = 32'($urandom_range(1, 9));
            if (isLongOp(op)) begin
                runLongOp("random_long", op, x, y, 0, MDU_NONE);
            end else begin
                start    = 1'($urandom_range(0, 1));
                mdu_type = op;
                a        = x;
                b        = y;
                #1;
                asserts++;
                if (rd_data !== ((op == MDU_MFHI) ? model[63:32] :
                                 (op == MDU_MFLO) ? model[31:0] : 32'd0)) begin
                    failures++;
                    $display("FAIL random read op=%0d: rd_data=%h hi_model=%h lo_model=%h",
                             op, rd_data, model[63:32], model[31:0]);
                end
                expV = start ? refResult(op, x, y, model) : model;
                nextCycle();
                start    = 1'b0;
                mdu_type = MDU_NONE;
                asserts++;
                if ({hi, lo} !== expV || busy !== 1'b0) begin
                    failures++;
                    $display("FAIL random short op=%0d: hi=%h lo=%h busy=%b expected hi=%h lo=%h busy=0",
                             op, hi, lo, busy, expV[63:32], expV[31:0]);
                end
                model = expV;
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_mult();
        test_div();
        test_div_by_zero();
        test_move_to();
        test_start_while_busy();
        test_back_to_back();
        test_reset_mid_op();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
        $finish;
    end

endmodule
